capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_sequencer.sv | 168 ++++++++++++++++
 tb/tb_capture_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Pre/post-trigger capture into a circular sample RAM, followed by an ordered readout of the window.
// Define CAPTURE_TIMEOUT_EN to force the trigger after TIMEOUT_CYC cycles spent armed.
module capture_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int PRE_DEPTH   = 256,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_pos,
    output logic              timed_out,
    output logic [2:0]        state
);

    // state | meaning
    // IDLE  | waiting for start, write address held at 0
    // PRE   | filling the pre-trigger history, trig ignored
    // ARMED | circular writes until trig (or forced trigger)
    // POST  | remaining writes after the trigger sample
    // READ  | issuing DEPTH reads, oldest sample first
    // DONE  | one-cycle completion pulse

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0]  PRE_LD  = CNT_W'(PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0]  POST_LD = CNT_W'(DEPTH - PRE_DEPTH - 2);
    localparam logic [CNT_W-1:0]  READ_LD = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRE_DEPTH);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    if (PRE_DEPTH < 1 || PRE_DEPTH > DEPTH - 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("capture_sequencer: illegal PRE_DEPTH or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           st;
    state_t           st_nx;
    logic [CNT_W-1:0] cnt;
    logic             forced;
    logic             trig_take;

    assign state     = st;
    assign trig_take = (st == S_ARMED) && !abort && (trig || forced);

    always_ff @(posedge clk) begin
        if (!rst) st <= S_IDLE;
        else      st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        wr_en = 1'b0;
        rd_en = 1'b0;
        busy  = (st != S_IDLE);
        done  = 1'b0;
        case (st)
            S_IDLE: begin
                if (start) st_nx = S_PRE;
            end
            S_PRE: begin
                wr_en = 1'b1;
                if (abort)           st_nx = S_IDLE;
                else if (cnt == '0)  st_nx = S_ARMED;
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (abort)                st_nx = S_IDLE;
                else if (trig || forced)  st_nx = S_POST;
            end
            S_POST: begin
                wr_en = 1'b1;
                if (abort)           st_nx = S_IDLE;
                else if (cnt == '0)  st_nx = S_READ;
            end
            S_READ: begin
                // cnt holds reads still to issue; it reaches 0 on the cycle the last beat is valid
                rd_en = out_ready && (cnt != '0);
                if (abort)           st_nx = S_IDLE;
                else if (cnt == '0)  st_nx = S_DONE;
            end
            S_DONE: begin
                done  = 1'b1;
                st_nx = S_IDLE;
            end
            default: st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            trig_pos  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (st == S_IDLE && st_nx == S_PRE)                   cnt <= PRE_LD;
            else if (st == S_ARMED && st_nx == S_POST)            cnt <= POST_LD;
            else if (st == S_POST && st_nx == S_READ)             cnt <= READ_LD;
            else if (st_nx == S_IDLE)                             cnt <= '0;
            else if ((st == S_PRE || st == S_POST) && cnt != '0)  cnt <= cnt - CNT_ONE;
            else if (rd_en)                                       cnt <= cnt - CNT_ONE;

            if (st == S_IDLE || st_nx == S_IDLE) wr_addr <= '0;
            else if (wr_en)                      wr_addr <= wr_addr + ADR_ONE;

            // oldest sample of the window sits PRE_DEPTH slots behind the trigger
            if (st == S_POST && st_nx == S_READ) rd_addr <= trig_pos - PRE_OFS;
            else if (rd_en)                      rd_addr <= rd_addr + ADR_ONE;

            if (trig_take) trig_pos <= wr_addr;

            out_valid <= rd_en && !abort;
            out_last  <= rd_en && !abort && (cnt == CNT_ONE);
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LD  = TO_W'(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    logic [TO_W-1:0] to_cnt;

    assign forced = (st == S_ARMED) && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else begin
            if (st == S_PRE && st_nx == S_ARMED)   to_cnt <= TO_LD;
            else if (st == S_ARMED && to_cnt != '0) to_cnt <= to_cnt - TO_ONE;
            else if (st != S_ARMED)                to_cnt <= '0;

            if (st == S_IDLE && start)   timed_out <= 1'b0;
            else if (trig_take && !trig) timed_out <= 1'b1;
        end
    end
`else
    assign forced    = 1'b0;
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: directed scenarios plus random traffic against a sample-level reference model.
module tb_capture_sequencer;
    localparam int ADDR_W = 4;
    localparam int PRE    = 4;
    localparam int D      = 1 << ADDR_W;
    localparam int TO     = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              trig = 1'b0;
    logic              out_ready = 1'b0;
    logic              wr_en, rd_en, out_valid, out_last, busy, done, timed_out;
    logic [ADDR_W-1:0] wr_addr, rd_addr, trig_pos;
    logic [2:0]        state;

    capture_sequencer #(.ADDR_W(ADDR_W), .PRE_DEPTH(PRE), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
        .busy(busy), .done(done), .trig_pos(trig_pos), .timed_out(timed_out),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // reference model: counts of writes/issues since capture start, addresses derived arithmetically
    int m_state = 0, m_nwr = 0, m_trig_pos = 0, m_trig_cyc = 0, m_issued = 0;
    int m_base = 0, m_armed = 0, m_post = 0, m_cyc = 0;
    bit m_valid = 1'b0, m_last = 1'b0, m_to = 1'b0;

    int mem [D];
    int rdata_q = 0, pend_exp = 0;
    int s_beats = 0, s_last_at = 0, s_first_rd = -1, s_issues = 0, s_dones = 0, s_read_cyc = 0, s_wr = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic go_idle();
        m_state = 0;
        m_nwr   = 0;
    endtask

    task automatic model_step();
        bit rd, fire, all_issued;
        rd         = (m_state == 4) && out_ready && (m_issued < D);
        all_issued = (m_issued == D);
        if (!rst) begin
            m_state = 0; m_nwr = 0; m_trig_pos = 0; m_issued = 0; m_base = 0;
            m_valid = 1'b0; m_last = 1'b0; m_to = 1'b0;
        end else begin
            m_valid = rd && !abort;
            m_last  = rd && !abort && (m_issued == D - 1);
            case (m_state)
                0: if (start) begin m_state = 1; m_nwr = 0; m_to = 1'b0; end
                1: if (abort) go_idle();
                   else begin
                       m_nwr++;
                       if (m_nwr == PRE) begin m_state = 2; m_armed = 0; end
                   end
                2: if (abort) go_idle();
                   else begin
                       fire = trig;
`ifdef CAPTURE_TIMEOUT_EN
                       if (m_armed == TO) begin
                           fire = 1'b1;
                           if (!trig) m_to = 1'b1;
                       end
`endif
                       if (fire) begin
                           m_trig_pos = m_nwr % D;
                           m_trig_cyc = m_cyc;
                           m_post     = 0;
                           m_state    = 3;
                       end
                       m_nwr++;
                       m_armed++;
                   end
                3: if (abort) go_idle();
                   else begin
                       m_nwr++;
                       m_post++;
                       if (m_post == D - PRE - 1) begin
                           m_state  = 4;
                           m_issued = 0;
                           m_base   = (m_trig_pos - PRE + D) % D;
                       end
                   end
                4: begin
                       if (rd) m_issued++;
                       if (abort)           go_idle();
                       else if (all_issued) m_state = 5;
                   end
                default: go_idle();
            endcase
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // per-cycle compare, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("state",     int'(state),     m_state);
            chk("busy",      int'(busy),      int'(m_state != 0));
            chk("done",      int'(done),      int'(m_state == 5));
            chk("wr_en",     int'(wr_en),     int'(m_state >= 1 && m_state <= 3));
            chk("wr_addr",   int'(wr_addr),   m_nwr % D);
            chk("rd_en",     int'(rd_en),     int'(m_state == 4 && out_ready && m_issued < D));
            chk("rd_addr",   int'(rd_addr),   (m_base + m_issued) % D);
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("out_last",  int'(out_last),  int'(m_last));
            chk("trig_pos",  int'(trig_pos),  m_trig_pos);
            chk("timed_out", int'(timed_out), int'(m_to));
            if (wr_en === 1'b1) mem[wr_addr] = m_cyc;
            if (m_valid) chk("rd_data", rdata_q, pend_exp);
            if (rd_en === 1'b1) begin
                rdata_q  = mem[rd_addr];
                pend_exp = m_trig_cyc - PRE + m_issued;
            end
            if (out_valid === 1'b1) begin
                s_beats++;
                if (out_last === 1'b1) s_last_at = s_beats;
            end
            if (rd_en === 1'b1) begin
                if (s_issues == 0) s_first_rd = int'(rd_addr);
                s_issues++;
            end
            if (done === 1'b1)  s_dones++;
            if (wr_en === 1'b1) s_wr++;
            if (state == 3'd4)  s_read_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        s_beats = 0; s_last_at = 0; s_first_rd = -1; s_issues = 0;
        s_dones = 0; s_read_cyc = 0; s_wr = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(state), s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < D; i++) mem[i] = 0;
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("reset_state",   int'(state),   0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_busy",    int'(busy),    0);
        tick();
        rst = 1'b1;
        tick();

        // trigger 10 cycles after armed entry, wrapping trig_pos
        clear_stats();
        out_ready = 1'b1;
        pulse_start();
        wait_state(2, 20, "a_armed");
        repeat (10) tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(0, 100, "a_idle");
        chk("a_trig_pos", int'(trig_pos), 14);
        chk("a_first_rd", s_first_rd, 10);
        chk("a_beats",    s_beats, 16);
        chk("a_last_at",  s_last_at, 16);
        chk("a_dones",    s_dones, 1);
        chk("a_writes",   s_wr, 26);
        tick();

        // trig held through PRE
        clear_stats();
        trig = 1'b1;
        pulse_start();
        wait_state(3, 20, "b_post");
        trig = 1'b0;
        wait_state(0, 100, "b_idle");
        chk("b_trig_pos", int'(trig_pos), 4);
        chk("b_first_rd", s_first_rd, 0);
        chk("b_beats",    s_beats, 16);
        tick();

        // out_ready toggling during readout
        clear_stats();
        out_ready = 1'b0;
        pulse_start();
        wait_state(2, 20, "c_armed");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(4, 30, "c_read");
        out_ready = 1'b1;
        for (int n = 0; n < 60 && state != 3'd0; n++) begin
            tick();
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        chk("c_beats",    s_beats, 16);
        chk("c_read_cyc", s_read_cyc, 32);
        chk("c_last_at",  s_last_at, 16);
        tick();

        // abort in POST
        clear_stats();
        pulse_start();
        wait_state(2, 20, "d_armed");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("d_abort_state", int'(state), 0);
        chk("d_abort_wr_en", int'(wr_en), 0);
        repeat (5) tick();
        chk("d_abort_dones", s_dones, 0);

        // start repeated during READ has no effect
        clear_stats();
        pulse_start();
        wait_state(2, 20, "d2_armed");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(4, 30, "d2_read");
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_state(0, 60, "d2_idle");
        chk("d2_dones", s_dones, 1);
        chk("d2_beats", s_beats, 16);
        tick();
        chk("d2_stays_idle", int'(state), 0);

        // reset during READ
        pulse_start();
        wait_state(2, 20, "e_armed");
        trig = 1'b1;
        tick();
        trig = 1'b0;
        wait_state(4, 30, "e_read");
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("e_rst_state",     int'(state),     0);
        chk("e_rst_rd_en",     int'(rd_en),     0);
        chk("e_rst_out_valid", int'(out_valid), 0);
        chk("e_rst_rd_addr",   int'(rd_addr),   0);
        chk("e_rst_trig_pos",  int'(trig_pos),  0);
        rst = 1'b1;
        clear_stats();
        pulse_start();
        chk("e_restart_state",   int'(state),   1);
        chk("e_restart_wr_addr", int'(wr_addr), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // armed without trig
        clear_stats();
        pulse_start();
        wait_state(2, 20, "f_armed");
`ifdef CAPTURE_TIMEOUT_EN
        begin
            int n = 0;
            while (state == 3'd2 && n < 40) begin
                tick();
                n++;
            end
            chk("f_armed_cycles", n, 21);
        end
        chk("f_trig_pos",  int'(trig_pos),  8);
        chk("f_timed_out", int'(timed_out), 1);
        wait_state(0, 60, "f_idle");
        chk("f_beats",      s_beats, 16);
        chk("f_held_flag",  int'(timed_out), 1);
        pulse_start();
        chk("f_flag_clear", int'(timed_out), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        repeat (30) tick();
        chk("f_still_armed", int'(state), 2);
        chk("f_timed_out",   int'(timed_out), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        tick();

        // random traffic
        clear_stats();
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 15) == 0);
            abort = ($urandom_range(0, 99) == 0);
`ifdef CAPTURE_TIMEOUT_EN
            trig  = ($urandom_range(0, 39) == 0);
`else
            trig  = ($urandom_range(0, 7) == 0);
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = !($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        chk("rand_completions", int'(s_dones > 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
